// File: rtl/finish_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : finish_seq_ctrl
//  Brief    : Initiator side of the finish_gen handshake. Accepts a job
//             (beat count) on a valid/ready port, programs finish_gen through
//             enable/clear/total_num, waits for finish and returns a
//             completion record carrying the elapsed RUN cycle count.
//  Options  : FINISH_SEQ_WATCHDOG_EN - adds a RUN-state watchdog that forces
//             completion with done_err=1 after TIMEOUT_CYC cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module finish_seq_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_num,
    output logic             gen_enable,
    output logic             gen_clear,
    output logic [CNT_W-1:0] gen_total_num,
    input  logic             gen_finish,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] done_cycles,
    output logic             done_err,
    output logic             busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_run   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             fin_q, fin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic w_accept;
    logic w_num_zero;
    logic w_fin_hit;
    logic w_timeout;

    assign w_accept   = req_valid && (state_q == c_st_idle);
    assign w_num_zero = (req_num == '0);
    // The first RUN cycle sees finish as sampled during CLEAR, which may still
    // be left over from the previous job; the counter is zero only there.
    assign w_fin_hit  = (state_q == c_st_run) && fin_q && (cnt_q != '0);

`ifdef FINISH_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);

    logic err_q, err_d;
    logic wd_clr_q, wd_clr_d;

    // A real finish in the same cycle as the limit wins over the watchdog.
    assign w_timeout = (state_q == c_st_run) && !w_fin_hit && (cnt_q >= c_timeout);

    // Error flag and the one-shot clear issued when the watchdog fires
    always_comb begin
        err_d    = err_q;
        wd_clr_d = w_timeout;
        if (w_accept) begin
            err_d = 1'b0;
        end else if (w_timeout) begin
            err_d = 1'b1;
        end
    end

    // Watchdog flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q    <= 1'b0;
            wd_clr_q <= 1'b0;
        end else begin
            err_q    <= err_d;
            wd_clr_q <= wd_clr_d;
        end
    end

    assign done_err = err_q;
`else
    assign w_timeout = 1'b0;
    assign done_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    state_d = w_num_zero ? c_st_done : c_st_clear;
                end
            end
            c_st_clear: state_d = c_st_run;
            c_st_run: begin
                if (w_fin_hit || w_timeout) begin
                    state_d = c_st_done;
                end
            end
            c_st_done: begin
                if (done_ready) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        req_ready  = (state_q == c_st_idle);
        gen_enable = (state_q == c_st_run);
        done_valid = (state_q == c_st_done);
        busy       = (state_q != c_st_idle);
`ifdef FINISH_SEQ_WATCHDOG_EN
        gen_clear  = (state_q == c_st_clear) || wd_clr_q;
`else
        gen_clear  = (state_q == c_st_clear);
`endif
    end

    // Datapath: job size latch, RUN cycle counter and completion count
    always_comb begin
        fin_d   = gen_finish;
        total_d = total_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        if (w_accept) begin
            cyc_d = '0;
            if (!w_num_zero) begin
                total_d = req_num;
            end
        end
        if (state_q == c_st_clear) begin
            cnt_d = '0;
        end else if (state_q == c_st_run) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
        if (w_fin_hit) begin
            cyc_d = cnt_q;
        end else if (w_timeout) begin
            cyc_d = cnt_q;
        end
    end

    // Datapath flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fin_q   <= 1'b0;
            total_q <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
        end else begin
            fin_q   <= fin_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    assign gen_total_num = total_q;
    assign done_cycles   = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_finish_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_finish_seq_ctrl
//  Brief    : Self-checking bench for finish_seq_ctrl with a behavioural
//             finish_gen model and arithmetic expectations per job.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_finish_seq_ctrl;

    localparam int CNT_W = 32;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [CNT_W-1:0] req_num = '0;
    logic             gen_enable;
    logic             gen_clear;
    logic [CNT_W-1:0] gen_total_num;
    logic             gen_finish;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic [CNT_W-1:0] done_cycles;
    logic             done_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_total = 0;

    // finish_gen model: counts enable beats, cleared by gen_clear; finish
    // rises fg_extra cycles late (random slack) unless muted.
    int   fg_beats = 0;
    int   fg_extra = 0;
    logic fg_mute  = 1'b0;
    logic fg_force = 1'b0;

    finish_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_num(req_num),
        .gen_enable(gen_enable), .gen_clear(gen_clear),
        .gen_total_num(gen_total_num), .gen_finish(gen_finish),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_cycles(done_cycles), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gen_clear) fg_beats <= 0;
        else if (gen_enable) fg_beats <= fg_beats + 1;
    end

    assign gen_finish = fg_force |
        (!fg_mute && (gen_total_num != '0) && (fg_beats >= int'(gen_total_num) + fg_extra));

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no end, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready), 64'd1);
        chk({tag, "_gen_enable"}, 64'(gen_enable), 64'd0);
        chk({tag, "_gen_clear"},  64'(gen_clear), 64'd0);
        chk({tag, "_total"},      64'(gen_total_num), 64'd0);
        chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
        chk({tag, "_done_cyc"},   64'(done_cycles), 64'd0);
        chk({tag, "_done_err"},   64'(done_err), 64'd0);
        chk({tag, "_busy"},       64'(busy), 64'd0);
    endtask

    // One job: num beats, finish slack 'extra', done_ready tied high or held
    // low for 'hold' cycles while a competing request is presented.
    task automatic run_job(input int num, input int extra, input bit tie, input int hold);
        int  t, first_en, clr_seen, en_seen, exp_t, exp_cyc, exp_en, exp_total;
        bit  got, stable;
        logic [CNT_W-1:0] snap;
        exp_cyc   = (num == 0) ? 0 : num + extra + 1;
        exp_t     = (num == 0) ? 1 : num + extra + 4;
        exp_en    = (num == 0) ? 0 : num + extra + 2;
        exp_total = (num == 0) ? prev_total : num;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        fg_extra = extra; req_num = CNT_W'(num); req_valid = 1'b1; done_ready = tie;
        @(posedge clk);
        #1 req_valid = 1'b0; req_num = $urandom;
        t = 0; first_en = -1; clr_seen = 0; en_seen = 0; got = 1'b0;
        while (!got && t < num + extra + 40) begin
            @(negedge clk); t++;
            if (t == 1) chk("accept_req_ready_low", 64'(req_ready), 64'd0);
            if (gen_clear) clr_seen++;
            if (gen_enable) begin
                en_seen++;
                if (first_en < 0) first_en = t;
            end
            if (done_valid) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done_latency", 64'(t), 64'(exp_t));
        chk("done_cycles", 64'(done_cycles), 64'(exp_cyc));
        chk("done_err", 64'(done_err), 64'd0);
        chk("clear_pulses", 64'(clr_seen), 64'(num != 0));
        chk("enable_cycles", 64'(en_seen), 64'(exp_en));
        chk("first_enable", 64'(first_en), 64'((num == 0) ? -1 : 2));
        chk("total_num", 64'(gen_total_num), 64'(exp_total));
        if (!tie) begin
            snap = done_cycles; stable = 1'b1;
            req_valid = 1'b1; req_num = 32'd999; fg_force = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                stable &= done_valid && (done_cycles == snap) && !req_ready && busy;
            end
            chk("hold_stable", 64'(stable), 64'd1);
            req_valid = 1'b0; fg_force = 1'b0; done_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_done_valid", 64'(done_valid), 64'd0);
        chk("post_req_ready", 64'(req_ready), 64'd1);
        chk("post_total_kept", 64'(gen_total_num), 64'(exp_total));
        done_ready = 1'b0;
        prev_total = exp_total;
    endtask

    initial begin
        int t;
        bit got, all_busy;
        // Reset
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rstn = 1'b1;

        // Directed jobs
        run_job(5, 0, 1'b1, 0);
        run_job(0, 0, 1'b0, 0);
        run_job(0, 0, 1'b1, 0);
        run_job(4, 1, 1'b0, 10);
        // finish pulses while idle must not start anything
        @(negedge clk); fg_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_finish_ignored", 64'({busy, done_valid}), 64'd0);
        fg_force = 1'b0;

        // Reset mid-RUN with a long job
        @(negedge clk);
        req_num = 32'd100; req_valid = 1'b1; done_ready = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("long_job_running", 64'(gen_enable), 64'd1);
        #2 rstn = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk); rstn = 1'b1; done_ready = 1'b0;
        prev_total = 0;
        run_job(3, 0, 1'b0, 2);

        // Back-to-back with done_ready high
        run_job(2, 0, 1'b1, 0);
        run_job(7, 0, 1'b1, 0);

        // Randomized jobs (kept below the watchdog limit)
        for (int i = 0; i < 8; i++) begin
            run_job(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        // finish_gen stuck: watchdog or indefinite wait
        fg_mute = 1'b1;
        @(negedge clk);
        req_num = 32'd5; req_valid = 1'b1; done_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
`ifdef FINISH_SEQ_WATCHDOG_EN
        t = 0; got = 1'b0;
        while (!got && t < 60) begin
            @(negedge clk); t++;
            if (done_valid) got = 1'b1;
        end
        chk("wd_done_seen", 64'(got), 64'd1);
        chk("wd_latency", 64'(t), 64'(TMO + 3));
        chk("wd_err", 64'(done_err), 64'd1);
        chk("wd_cycles", 64'(done_cycles), 64'(TMO));
        chk("wd_enable_low", 64'(gen_enable), 64'd0);
        chk("wd_clear_pulse", 64'(gen_clear), 64'd1);
        @(negedge clk);
        chk("wd_clear_once", 64'(gen_clear), 64'd0);
        done_ready = 1'b1;
        @(negedge clk);
        chk("wd_back_idle", 64'(req_ready), 64'd1);
        done_ready = 1'b0;
`else
        got = 1'b0; all_busy = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done_valid) got = 1'b1;
            all_busy &= busy;
        end
        chk("stuck_busy", 64'(all_busy), 64'd1);
        chk("stuck_no_done", 64'(got), 64'd0);
        chk("stuck_enable", 64'(gen_enable), 64'd1);
        chk("stuck_err", 64'(done_err), 64'd0);
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
`endif
        fg_mute = 1'b0;
        @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/finish_seq_ctrl.md
Name: finish_seq_ctrl

Overview:
- Initiator side of the finish_gen handshake.
- Accepts job requests (a count of beats) over a valid/ready port and programs finish_gen through enable/clear/total_num.
- Waits for finish, then returns a completion record with the elapsed cycle count on a second valid/ready port.
- Sits between the testbench/host sequencer and finish_gen in the SFU control path.

Parameters:
- CNT_W, 32, width of the job count, total_num and cycle counter
- TIMEOUT_CYC, 1024, watchdog limit in cycles spent in RUN (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  job request accepted when req_valid && req_ready
- req_num  in  CNT_W  number of cnt_enable beats for the job
- gen_enable  out  1  drives finish_gen enable
- gen_clear  out  1  drives finish_gen clear (single-cycle pulse)
- gen_total_num  out  CNT_W  drives finish_gen total_num
- gen_finish  in  1  finish from finish_gen
- done_valid  out  1  completion record valid
- done_ready  in  1  completion consumer ready
- done_cycles  out  CNT_W  cycles from entry into RUN to gen_finish sampled high
- done_err  out  1  completion ended by watchdog (0 when feature compiled out)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock. Reset is asynchronous, active-low (rstn), and is the only asynchronous path.
- Reset values: req_ready=1, gen_enable=0, gen_clear=0, gen_total_num=0, done_valid=0, done_cycles=0, done_err=0, busy=0. FSM resets to IDLE.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On accept with req_num!=0: latch req_num into gen_total_num, pulse gen_clear for 1 cycle, go to CLEAR.
  - On accept with req_num==0: go directly to DONE with done_cycles=0, done_err=0. finish_gen is not touched.
- CLEAR:
  - One cycle; gen_clear=1 here only.
  - Next state RUN; cycle counter reset to 0.
- RUN:
  - gen_enable=1. Cycle counter increments every cycle and saturates at all-ones.
  - gen_finish sampled high (registered input, not combinational): latch counter into done_cycles, drop gen_enable the next cycle, go to DONE.
  - gen_finish high on the first RUN cycle is treated as a stale finish and ignored; this guards against finish_gen clear latency.
- DONE:
  - done_valid=1 and held stable until done_ready.
  - On done_valid && done_ready: go to IDLE. done_valid drops the next cycle.
  - req_ready rises in the same edge, so there is no bubble beyond that one cycle.
- req_ready=0 in CLEAR, RUN and DONE. One job outstanding at most.
- gen_total_num holds its value until the next accepted job; it is not cleared on completion.
- Latency, accept to first gen_enable cycle: 2 clocks (IDLE->CLEAR->RUN).
- Minimum job turnaround with done_ready tied high: N + 4 cycles.
- Reset asserted mid-job: everything returns to reset values immediately. A partially counted job is discarded and no completion record is produced.
- gen_finish outside RUN is ignored.

Optional Feature:
- Macro: FINISH_SEQ_WATCHDOG_EN.
- Defined:
  - In RUN, counter reaching TIMEOUT_CYC with no gen_finish forces DONE with done_err=1 and done_cycles=TIMEOUT_CYC.
  - gen_enable drops and gen_clear pulses once on exit, leaving finish_gen clean.
- Undefined:
  - No watchdog; RUN waits indefinitely.
  - done_err tied to 0.
  - TIMEOUT_CYC unused.

Test Plan:
- Reset, then req_num=5; model finish_gen responds after 5 enable cycles -> gen_clear one pulse, gen_enable high from cycle +2, done_valid with done_cycles=6, done_err=0.
- req_num=0 -> req_ready drops 1 cycle, done_valid next cycle with done_cycles=0; gen_clear and gen_enable never assert.
- done_ready held low 10 cycles after completion -> done_valid and done_cycles stable; req_ready stays 0; new req_valid not accepted until the handshake completes.
- rstn pulled low while in RUN with req_num=100 -> all outputs return to reset values asynchronously; after release, a fresh req_num=3 completes normally.
- Back-to-back jobs 2 then 7, done_ready=1 -> two completions in order; gen_total_num reads 2 then 7; exactly two gen_clear pulses.
- FINISH_SEQ_WATCHDOG_EN with TIMEOUT_CYC=16 and gen_finish held 0 -> done_err=1, done_cycles=16, gen_enable low and one gen_clear pulse on exit; same stimulus without the macro -> busy stays 1, no done_valid.
